// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, paddle defaults and paddle command helper.
package vga_timing_pkg;

    localparam int unsigned PIX_W         = 10;

    localparam int unsigned CLK_DIV_DEF   = 2;
    localparam int unsigned H_TOTAL       = 800;
    localparam int unsigned V_TOTAL       = 525;
    localparam int unsigned H_ACT_FIRST   = 144;
    localparam int unsigned H_ACT_LAST    = 783;
    localparam int unsigned V_ACT_FIRST   = 35;
    localparam int unsigned V_ACT_LAST    = 514;

    localparam int unsigned PADDLE_RADIUS = 13;
    localparam int unsigned POS_INIT_DEF  = 275;
    localparam int unsigned POS_MIN_DEF   = 48;
    localparam int unsigned POS_MAX_DEF   = 501;
    localparam int unsigned POS_STEP_DEF  = 4;

    typedef enum logic [1:0] {
        PAD_HOLD = 2'd0,
        PAD_UP   = 2'd1,
        PAD_DOWN = 2'd2
    } pad_cmd_e;

    // Both or neither button pressed means the paddle stays where it is.
    function automatic pad_cmd_e pad_cmd(input logic up, input logic down);
        pad_cmd_e cmd;
        cmd = PAD_HOLD;
        if (up && !down) begin
            cmd = PAD_UP;
        end else if (down && !up) begin
            cmd = PAD_DOWN;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/paddle_pos_ctrl.sv
// One paddle centre-line register, moved once per frame and clamped to its limits.
module paddle_pos_ctrl
    import vga_timing_pkg::*;
#(
    parameter int unsigned POS_INIT = POS_INIT_DEF,
    parameter int unsigned POS_MIN  = POS_MIN_DEF,
    parameter int unsigned POS_MAX  = POS_MAX_DEF,
    parameter int unsigned POS_STEP = POS_STEP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             up,
    input  logic             down,
    output logic [PIX_W-1:0] pos
);

    localparam logic [PIX_W:0] STEP_X   = (PIX_W+1)'(POS_STEP);
    localparam logic [PIX_W:0] MIN_X    = (PIX_W+1)'(POS_MIN);
    localparam logic [PIX_W:0] MAX_X    = (PIX_W+1)'(POS_MAX);
    localparam logic [PIX_W:0] UP_FLOOR = (PIX_W+1)'(POS_MIN + POS_STEP);

    pad_cmd_e         cmd;
    logic [PIX_W:0]   pos_x;
    logic [PIX_W:0]   dec_x;
    logic [PIX_W:0]   inc_x;
    logic [PIX_W-1:0] pos_next;

    // Candidate next position; widened by one bit so the clamp sees true values.
    always_comb begin
        cmd      = pad_cmd(up, down);
        pos_x    = {1'b0, pos};
        dec_x    = pos_x - STEP_X;
        inc_x    = pos_x + STEP_X;
        pos_next = pos;
        unique case (cmd)
            PAD_UP: begin
                // Compare before subtracting so a position below the step can never wrap.
                if (pos_x < UP_FLOOR) begin
                    pos_next = MIN_X[PIX_W-1:0];
                end else begin
                    pos_next = dec_x[PIX_W-1:0];
                end
            end
            PAD_DOWN: begin
                if (inc_x > MAX_X) begin
                    pos_next = MAX_X[PIX_W-1:0];
                end else begin
                    pos_next = inc_x[PIX_W-1:0];
                end
            end
            default: begin
                pos_next = pos;
            end
        endcase
    end

    // Position register, updated only on the frame tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos <= PIX_W'(POS_INIT);
        end else if (tick) begin
            pos <= pos_next;
        end
    end

endmodule

// File: rtl/vga_scan_generator.sv
// Pixel-rate divider, horizontal/vertical scan counters and per-frame paddle positions.
module vga_scan_generator
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV     = CLK_DIV_DEF,
    parameter int unsigned H_TOTAL     = vga_timing_pkg::H_TOTAL,
    parameter int unsigned V_TOTAL     = vga_timing_pkg::V_TOTAL,
    parameter int unsigned H_ACT_FIRST = vga_timing_pkg::H_ACT_FIRST,
    parameter int unsigned H_ACT_LAST  = vga_timing_pkg::H_ACT_LAST,
    parameter int unsigned V_ACT_FIRST = vga_timing_pkg::V_ACT_FIRST,
    parameter int unsigned V_ACT_LAST  = vga_timing_pkg::V_ACT_LAST,
    parameter int unsigned POS_INIT    = POS_INIT_DEF,
    parameter int unsigned POS_MIN     = POS_MIN_DEF,
    parameter int unsigned POS_MAX     = POS_MAX_DEF,
    parameter int unsigned POS_STEP    = POS_STEP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             team1_up,
    input  logic             team1_down,
    input  logic             team2_up,
    input  logic             team2_down,
    output logic             pixel_en,
    output logic [PIX_W-1:0] current_pixel,
    output logic [PIX_W-1:0] current_line,
    output logic             video_active,
    output logic             frame_tick,
    output logic [PIX_W-1:0] team1_ver_pos,
    output logic [PIX_W-1:0] team2_ver_pos
);

    // A one-bit divider stuck at 0 covers CLK_DIV=1, which keeps pixel_en high.
    localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [PIX_W-1:0] H_LAST   = PIX_W'(H_TOTAL - 1);
    localparam logic [PIX_W-1:0] V_LAST   = PIX_W'(V_TOTAL - 1);
    localparam logic [PIX_W-1:0] H_FIRST_A = PIX_W'(H_ACT_FIRST);
    localparam logic [PIX_W-1:0] H_LAST_A  = PIX_W'(H_ACT_LAST);
    localparam logic [PIX_W-1:0] V_FIRST_A = PIX_W'(V_ACT_FIRST);
    localparam logic [PIX_W-1:0] V_LAST_A  = PIX_W'(V_ACT_LAST);

    logic [DIV_W-1:0] div;
    logic             h_at_last;
    logic             v_at_last;

    // Clock divider: counts 0..CLK_DIV-1 and wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Decodes of registered state: pixel strobe, frame tick and visible window.
    always_comb begin
        pixel_en     = (div == DIV_LAST);
        h_at_last    = (current_pixel == H_LAST);
        v_at_last    = (current_line == V_LAST);
        frame_tick   = pixel_en && h_at_last && v_at_last;
        video_active = (current_pixel >= H_FIRST_A) && (current_pixel <= H_LAST_A) &&
                       (current_line  >= V_FIRST_A) && (current_line  <= V_LAST_A);
    end

    // Scan counters, advancing once per pixel strobe; line steps when the pixel wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            current_pixel <= '0;
            current_line  <= '0;
        end else if (pixel_en) begin
            if (h_at_last) begin
                current_pixel <= '0;
                if (v_at_last) begin
                    current_line <= '0;
                end else begin
                    current_line <= current_line + 1'b1;
                end
            end else begin
                current_pixel <= current_pixel + 1'b1;
            end
        end
    end

    paddle_pos_ctrl #(
        .POS_INIT (POS_INIT),
        .POS_MIN  (POS_MIN),
        .POS_MAX  (POS_MAX),
        .POS_STEP (POS_STEP)
    ) u_team1 (
        .clk  (clk),
        .rst  (rst),
        .tick (frame_tick),
        .up   (team1_up),
        .down (team1_down),
        .pos  (team1_ver_pos)
    );

    paddle_pos_ctrl #(
        .POS_INIT (POS_INIT),
        .POS_MIN  (POS_MIN),
        .POS_MAX  (POS_MAX),
        .POS_STEP (POS_STEP)
    ) u_team2 (
        .clk  (clk),
        .rst  (rst),
        .tick (frame_tick),
        .up   (team2_up),
        .down (team2_down),
        .pos  (team2_ver_pos)
    );

endmodule

// File: tb/tb_vga_scan_generator.sv
// Scoreboarded bench for vga_scan_generator on a shrunken 20x10 raster.
module tb_vga_scan_generator;
    import vga_timing_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             team1_up = 1'b0;
    logic             team1_down = 1'b0;
    logic             team2_up = 1'b0;
    logic             team2_down = 1'b0;
    logic             pixel_en;
    logic [PIX_W-1:0] current_pixel;
    logic [PIX_W-1:0] current_line;
    logic             video_active;
    logic             frame_tick;
    logic [PIX_W-1:0] team1_ver_pos;
    logic [PIX_W-1:0] team2_ver_pos;

    // Raster 20 pixels x 10 lines, 2 clocks per pixel: 400 clocks per frame.
    vga_scan_generator #(
        .CLK_DIV     (2),
        .H_TOTAL     (20),
        .V_TOTAL     (10),
        .H_ACT_FIRST (4),
        .H_ACT_LAST  (15),
        .V_ACT_FIRST (2),
        .V_ACT_LAST  (8),
        .POS_INIT    (275),
        .POS_MIN     (48),
        .POS_MAX     (501),
        .POS_STEP    (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .team1_up      (team1_up),
        .team1_down    (team1_down),
        .team2_up      (team2_up),
        .team2_down    (team2_down),
        .pixel_en      (pixel_en),
        .current_pixel (current_pixel),
        .current_line  (current_line),
        .video_active  (video_active),
        .frame_tick    (frame_tick),
        .team1_ver_pos (team1_ver_pos),
        .team2_ver_pos (team2_ver_pos)
    );

    always #5 clk = ~clk;

    typedef enum int {K_PE, K_PIX, K_LINE, K_VA, K_FT, K_FTCNT, K_P1, K_P2} kind_e;
    typedef struct {
        int    ep;
        int    at;
        kind_e kind;
        int    exp;
        string name;
    } chk_t;

    chk_t q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   n          = 0;   // clocks since the last reset edge
    int   epoch      = 0;   // number of reset edges seen
    int   tick_cnt   = 0;

    // Cycle stamp: state index since reset, plus which reset it belongs to.
    always @(posedge clk) begin
        if (rst) begin
            n     <= 0;
            epoch <= epoch + 1;
        end else begin
            n <= n + 1;
        end
    end

    function automatic void expect_at(input int ep, input int at, input kind_e k,
                                      input int v, input string nm);
        chk_t c;
        c.ep   = ep;
        c.at   = at;
        c.kind = k;
        c.exp  = v;
        c.name = nm;
        q.push_back(c);
    endfunction

    // Monitor: on every falling edge pop the expectations scheduled for this cycle.
    initial begin
        int          last_ep;
        chk_t        c;
        logic [31:0] act;
        last_ep = 0;
        forever begin
            @(negedge clk);
            if (epoch != last_ep) begin
                tick_cnt = 0;
                last_ep  = epoch;
            end
            if (frame_tick === 1'b1) tick_cnt = tick_cnt + 1;
            while (q.size() > 0 &&
                   (q[0].ep < epoch || (q[0].ep == epoch && q[0].at <= n))) begin
                c = q.pop_front();
                compared = compared + 1;
                if (c.ep != epoch || c.at != n) begin
                    mismatched = mismatched + 1;
                    $display("FAIL %s missed: scheduled ep%0d n=%0d, reached ep%0d n=%0d",
                             c.name, c.ep, c.at, epoch, n);
                end else begin
                    case (c.kind)
                        K_PE:    act = {31'b0, pixel_en};
                        K_PIX:   act = {22'b0, current_pixel};
                        K_LINE:  act = {22'b0, current_line};
                        K_VA:    act = {31'b0, video_active};
                        K_FT:    act = {31'b0, frame_tick};
                        K_FTCNT: act = tick_cnt;
                        K_P1:    act = {22'b0, team1_ver_pos};
                        default: act = {22'b0, team2_ver_pos};
                    endcase
                    if (act !== 32'(c.exp)) begin
                        mismatched = mismatched + 1;
                        $display("FAIL %s ep%0d n=%0d: got %0d, want %0d",
                                 c.name, epoch, n, act, c.exp);
                    end
                end
            end
        end
    end

    task automatic wait_n(input int ep, input int at);
        for (int i = 0; i < 40000; i++) begin
            if (epoch == ep && n == at) return;
            @(negedge clk);
        end
        mismatched = mismatched + 1;
        $display("FAIL wait_n timeout: waiting for ep%0d n=%0d, at ep%0d n=%0d", ep, at, epoch, n);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "timeout");
    endtask

    // Called on a falling edge; returns on the falling edge of the first post-reset cycle.
    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int pe_tab  [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
        int pix_tab [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4};

        // Epoch 1: reset values, divider cadence, window edges, frame wrap.
        for (int i = 0; i < 10; i++) begin
            expect_at(1, i, K_PE,   pe_tab[i],  "pe_start");
            expect_at(1, i, K_PIX,  pix_tab[i], "pix_start");
            expect_at(1, i, K_LINE, 0,          "line_start");
            if (i == 0) begin
                expect_at(1, 0, K_P1, 275, "p1_reset");
                expect_at(1, 0, K_P2, 275, "p2_reset");
                expect_at(1, 0, K_FT, 0,   "ft_reset");
            end
        end
        expect_at(1, 48,  K_VA, 0, "va_4_1");
        expect_at(1, 86,  K_VA, 0, "va_3_2");
        expect_at(1, 88,  K_VA, 1, "va_4_2");
        expect_at(1, 350, K_VA, 1, "va_15_8");
        expect_at(1, 352, K_VA, 0, "va_16_8");
        expect_at(1, 398, K_PIX,  19, "pix_last");
        expect_at(1, 398, K_LINE, 9,  "line_last");
        expect_at(1, 398, K_FT,   0,  "ft_div0");
        expect_at(1, 399, K_FT,   1,  "ft_pulse");
        expect_at(1, 399, K_PE,   1,  "pe_at_ft");
        expect_at(1, 400, K_PIX,  0,  "pix_wrap");
        expect_at(1, 400, K_LINE, 0,  "line_wrap");
        expect_at(1, 400, K_FT,   0,  "ft_after");
        expect_at(1, 400, K_FTCNT, 1, "ft_once");

        // Epoch 2: team1 up for three frames, team2 both buttons held.
        expect_at(2, 0,    K_P1, 275, "p1_e2_reset");
        expect_at(2, 399,  K_P1, 275, "p1_before_tick");
        expect_at(2, 399,  K_FT, 1,   "ft_e2");
        expect_at(2, 400,  K_P1, 271, "p1_f1");
        expect_at(2, 400,  K_P2, 275, "p2_f1_hold");
        expect_at(2, 800,  K_P1, 267, "p1_f2");
        expect_at(2, 800,  K_P2, 275, "p2_f2_hold");
        expect_at(2, 1200, K_P1, 263, "p1_f3");
        expect_at(2, 1200, K_P2, 275, "p2_f3_hold");
        expect_at(2, 1200, K_FTCNT, 3, "ft_cnt3");

        // Epoch 3: clamp both paddles, then walk team1 back down to 100.
        expect_at(3, 0,     K_P1, 275, "p1_e3_reset");
        expect_at(3, 4000,  K_P1, 235, "p1_f10");
        expect_at(3, 4000,  K_P2, 315, "p2_f10");
        expect_at(3, 22400, K_P1, 51,  "p1_f56");
        expect_at(3, 22400, K_P2, 499, "p2_f56");
        expect_at(3, 22800, K_P1, 48,  "p1_clamp_min");
        expect_at(3, 22800, K_P2, 501, "p2_clamp_max");
        expect_at(3, 24000, K_P1, 48,  "p1_sat");
        expect_at(3, 24000, K_P2, 501, "p2_sat");
        expect_at(3, 24000, K_FTCNT, 60, "ft_cnt60");
        expect_at(3, 29200, K_P1, 100, "p1_back100");
        expect_at(3, 29200, K_P2, 501, "p2_hold501");
        expect_at(3, 29420, K_PIX,  10,  "pix_mid");
        expect_at(3, 29420, K_LINE, 5,   "line_mid");
        expect_at(3, 29420, K_VA,   1,   "va_mid");
        expect_at(3, 29420, K_P1,   100, "p1_mid");

        // Epoch 4: state right after a mid-frame reset pulse.
        expect_at(4, 0, K_PIX,  0,   "pix_rst_mid");
        expect_at(4, 0, K_LINE, 0,   "line_rst_mid");
        expect_at(4, 0, K_P1,   275, "p1_rst_mid");
        expect_at(4, 0, K_P2,   275, "p2_rst_mid");
        expect_at(4, 0, K_FT,   0,   "ft_rst_mid");
        expect_at(4, 0, K_PE,   0,   "pe_rst_mid");
        expect_at(4, 0, K_FTCNT, 0,  "ft_cnt_rst");

        @(negedge clk);
        rst = 1'b0;

        wait_n(1, 401);
        pulse_rst();
        team1_up   = 1'b1;
        team2_up   = 1'b1;
        team2_down = 1'b1;

        wait_n(2, 1201);
        pulse_rst();
        team1_up   = 1'b1;
        team2_up   = 1'b0;
        team2_down = 1'b1;

        wait_n(3, 24000);
        team1_up   = 1'b0;
        team1_down = 1'b1;
        team2_down = 1'b0;

        wait_n(3, 29420);
        pulse_rst();
        team1_down = 1'b0;

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (q.size() > 0) begin
            compared   = compared + q.size();
            mismatched = mismatched + q.size();
            $display("FAIL drain: %0d checks still pending, want 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
